gpio_pad_ctrl: RTL and testbench
================================

// Module: gpio_pad_ctrl
// PURPOSE
//   Per-pin controller for a bank of tri-state GPIO pads (tri_p[ud]_pad_[hv]). Sequences direction changes through
//   guarded turnaround states, drives pad i/oen/ren, synchronises and optionally debounces pad readback, and
//   detects rise/fall edges into sticky interrupt-pending bits. Sits between GPIO register block and pad ring.
// PARAMETERS
//   NUM_PINS      8  pins in the bank
//   SYNC_STAGES   2  synchroniser flops on pad_c_i (>=2)
//   TURN_CYCLES   2  tri-state guard cycles on direction change (>=1)
//   DB_CNT_WIDTH  8  debounce counter/threshold width
// PORTS
//   clk_i        in   1             clock
//   rst_i        in   1             reset, asynchronous, active-high
//   dir_i        in   NUM_PINS      1=output, 0=input
//   out_i        in   NUM_PINS      output data
//   pull_en_i    in   NUM_PINS      1=enable pad pull resistor
//   rise_en_i    in   NUM_PINS      rising-edge interrupt enable
//   fall_en_i    in   NUM_PINS      falling-edge interrupt enable
//   irq_clr_i    in   NUM_PINS      1-cycle pulse, clears pending bit
//   db_thresh_i  in   DB_CNT_WIDTH  debounce stable-cycle threshold
//   in_o         out  NUM_PINS      synchronised/debounced pin value
//   irq_pend_o   out  NUM_PINS      sticky edge-pending bits
//   irq_o        out  1             OR of irq_pend_o, registered
//   pad_i_o      out  NUM_PINS      to pad i_i
//   pad_oen_o    out  NUM_PINS      to pad oen_i, 1=tri-state
//   pad_ren_o    out  NUM_PINS      to pad ren_i, active-low (0=pull on)
//   pad_c_i      in   NUM_PINS      from pad c_o
// BEHAVIOUR
//   Reset (async, immediate): pad_oen_o=all 1, pad_i_o=0, pad_ren_o=all 1, in_o=0, irq_pend_o=0, irq_o=0,
//     sync flops 0, counters 0, all FSMs IN. Reset mid-turnaround aborts to IN; pad released same instant.
//   pad_i_o <= out_i, pad_ren_o <= ~pull_en_i every cycle, all states (1-cycle latency).
//   Per-pin FSM (state and pad_oen_o registered together; pad_oen_o=0 only in OUT):
//     IN      : dir=1 -> TURN_OUT, tcnt=0.
//     TURN_OUT: tri-stated; dir=0 -> IN (abort); tcnt==TURN_CYCLES-1 -> OUT; else tcnt++.
//     OUT     : dir=0 -> TURN_IN, tcnt=0.
//     TURN_IN : tri-stated; holds TURN_CYCLES+SYNC_STAGES+1 cycles -> IN; dir=1 -> TURN_OUT, tcnt=0.
//   dir_i 0->1 sampled at edge E0: pad_oen_o falls after edge E0+TURN_CYCLES-1... i.e. TURN_CYCLES+1 edges total.
//   dir_i 1->0 sampled at edge E0: pad_oen_o rises at E0 (1 edge).
//   Input path: pad_c_i -> SYNC_STAGES flops -> in_o flop; latency SYNC_STAGES+1 edges. in_o tracks readback in all states.
//   Edge detect on in_o update: rise=0->1 & rise_en, fall=1->0 & fall_en; sets irq_pend same edge in_o changes.
//     Edges ignored unless FSM==IN. Set and irq_clr_i same cycle: set wins (pend stays 1).
//   irq_o <= |irq_pend_o (1 edge after pend).
//   rise_en/fall_en deassertion does not clear pending bits.
// CONFIGURATION
//   GPIO_PAD_CTRL_DEBOUNCE_EN defined: per-pin counter; counts cycles sync_out != in_o, clears to 0 when equal;
//     when count==db_thresh_i, in_o <= sync_out, count <= 0. Latency SYNC_STAGES+1+db_thresh_i; thresh 0 = no debounce.
//     Counter saturates at all-ones; thresh changes take effect next cycle. TURN_IN hold extended by db_thresh_i.
//   Undefined: no counters; db_thresh_i unused; in_o <= sync_out every cycle.
// TESTING
//   1 Reset: assert rst_i while pin 0 in OUT, out=1 -> pad_oen_o=FF, pad_i_o=00, pad_ren_o=FF, irq_o=0 without clock.
//   2 Turnaround: TURN_CYCLES=2, dir[0] 0->1 -> pad_oen_o[0]=0 after 3rd edge; dir 1->0 -> oen=1 next edge,
//     pad_c toggles during TURN_IN never set irq_pend[0].
//   3 Abort: dir[1] pulses 1 for 1 cycle -> FSM IN->TURN_OUT->IN, pad_oen_o[1] stays 1 throughout.
//   4 Edge irq (no debounce): pin 3 input, rise_en[3]=1, pad_c[3] 0->1 -> in_o[3]=1 and irq_pend[3]=1 after 3 edges,
//     irq_o=1 after 4; fall with fall_en=0 -> pend unchanged.
//   5 Clear race: irq_clr_i[3] asserted same cycle as new rise on pin 3 -> irq_pend[3] remains 1; clr alone -> 0.
//   6 Debounce (_EN): db_thresh=4, pad glitch high 3 cycles -> in_o unchanged; high 8 cycles -> in_o=1 after 7 edges.

Source files
------------

// File: rtl/gpio_pad_ctrl.sv
// Per-pin GPIO pad controller: guarded direction turnaround, pad drive, synchronised readback, sticky edge IRQs.
// Define GPIO_PAD_CTRL_DEBOUNCE_EN to add a per-pin stable-count debounce on the readback path.
module gpio_pad_ctrl #(
    parameter int unsigned NUM_PINS     = 8,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned TURN_CYCLES  = 2,
    parameter int unsigned DB_CNT_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_PINS-1:0]     dir_i,
    input  logic [NUM_PINS-1:0]     out_i,
    input  logic [NUM_PINS-1:0]     pull_en_i,
    input  logic [NUM_PINS-1:0]     rise_en_i,
    input  logic [NUM_PINS-1:0]     fall_en_i,
    input  logic [NUM_PINS-1:0]     irq_clr_i,
    input  logic [DB_CNT_WIDTH-1:0] db_thresh_i,
    output logic [NUM_PINS-1:0]     in_o,
    output logic [NUM_PINS-1:0]     irq_pend_o,
    output logic                    irq_o,
    output logic [NUM_PINS-1:0]     pad_i_o,
    output logic [NUM_PINS-1:0]     pad_oen_o,
    output logic [NUM_PINS-1:0]     pad_ren_o,
    input  logic [NUM_PINS-1:0]     pad_c_i
);

    localparam int unsigned TW = $clog2(TURN_CYCLES + SYNC_STAGES + 2) + DB_CNT_WIDTH + 1;
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);
    localparam logic [TW-1:0] HOLD_BASE = TW'(TURN_CYCLES + SYNC_STAGES);
    localparam logic [TW-1:0] T_ONE     = TW'(1);

    typedef enum logic [1:0] {ST_IN, ST_TURN_OUT, ST_OUT, ST_TURN_IN} state_t;

    state_t              state [NUM_PINS];
    logic [TW-1:0]       tcnt  [NUM_PINS];
    logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
    logic [NUM_PINS-1:0] sync_out;
    logic [NUM_PINS-1:0] in_next;
    logic [NUM_PINS-1:0] in_mode;
    logic [NUM_PINS-1:0] edge_set;
    logic [TW-1:0]       hold_last;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
        end else begin
            sync_q[0] <= pad_c_i;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
        end
    end

`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
    localparam logic [DB_CNT_WIDTH-1:0] DB_ONE = DB_CNT_WIDTH'(1);
    logic [DB_CNT_WIDTH-1:0] db_cnt [NUM_PINS];

    always_comb begin
        in_next = in_o;
        for (int unsigned p = 0; p < NUM_PINS; p++) begin
            if (sync_out[p] != in_o[p] && db_cnt[p] == db_thresh_i) in_next[p] = sync_out[p];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned p = 0; p < NUM_PINS; p++) db_cnt[p] <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PINS; p++) begin
                if (sync_out[p] == in_o[p] || db_cnt[p] == db_thresh_i) db_cnt[p] <= '0;
                else if (db_cnt[p] != '1) db_cnt[p] <= db_cnt[p] + DB_ONE;
            end
        end
    end

    // Readback settles db_thresh_i cycles later, so the input-side guard grows with it.
    assign hold_last = HOLD_BASE + TW'(db_thresh_i);
`else
    logic unused_db_thresh;
    assign unused_db_thresh = ^db_thresh_i;
    assign in_next   = sync_out;
    assign hold_last = HOLD_BASE;
`endif

    always_comb begin
        in_mode = '0;
        for (int unsigned p = 0; p < NUM_PINS; p++) in_mode[p] = (state[p] == ST_IN);
    end

    assign edge_set = in_mode & ((~in_o & in_next & rise_en_i) | (in_o & ~in_next & fall_en_i));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pad_i_o    <= '0;
            pad_ren_o  <= '1;
            in_o       <= '0;
            irq_pend_o <= '0;
            irq_o      <= 1'b0;
        end else begin
            pad_i_o    <= out_i;
            pad_ren_o  <= ~pull_en_i;
            in_o       <= in_next;
            irq_pend_o <= (irq_pend_o & ~irq_clr_i) | edge_set;
            irq_o      <= |irq_pend_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned p = 0; p < NUM_PINS; p++) begin
                state[p] <= ST_IN;
                tcnt[p]  <= '0;
            end
            pad_oen_o <= '1;
        end else begin
            for (int unsigned p = 0; p < NUM_PINS; p++) begin
                case (state[p])
                    ST_IN: begin
                        if (dir_i[p]) begin
                            state[p] <= ST_TURN_OUT;
                            tcnt[p]  <= '0;
                        end
                    end
                    ST_TURN_OUT: begin
                        if (!dir_i[p]) begin
                            state[p] <= ST_IN;
                        end else if (tcnt[p] == TURN_LAST) begin
                            state[p]     <= ST_OUT;
                            pad_oen_o[p] <= 1'b0;
                        end else begin
                            tcnt[p] <= tcnt[p] + T_ONE;
                        end
                    end
                    ST_OUT: begin
                        if (!dir_i[p]) begin
                            state[p]     <= ST_TURN_IN;
                            tcnt[p]      <= '0;
                            pad_oen_o[p] <= 1'b1;
                        end
                    end
                    ST_TURN_IN: begin
                        if (dir_i[p]) begin
                            state[p] <= ST_TURN_OUT;
                            tcnt[p]  <= '0;
                        end else if (tcnt[p] >= hold_last) begin
                            state[p] <= ST_IN;
                        end else begin
                            tcnt[p] <= tcnt[p] + T_ONE;
                        end
                    end
                    default: begin
                        state[p]     <= ST_IN;
                        pad_oen_o[p] <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Randomised + directed bench for gpio_pad_ctrl against a history-based behavioural model.
module tb_gpio_pad_ctrl;

    localparam int N  = 8;
    localparam int S  = 2;
    localparam int T  = 2;
    localparam int DW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [N-1:0]  dir_i = '0, out_i = '0, pull_en_i = '0, rise_en_i = '0, fall_en_i = '0;
    logic [N-1:0]  irq_clr_i = '0, pad_c_i = '0;
    logic [DW-1:0] db_thresh_i = '0;
    logic [N-1:0]  in_o, irq_pend_o, pad_i_o, pad_oen_o, pad_ren_o;
    logic          irq_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    gpio_pad_ctrl #(
        .NUM_PINS(N), .SYNC_STAGES(S), .TURN_CYCLES(T), .DB_CNT_WIDTH(DW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .dir_i(dir_i), .out_i(out_i), .pull_en_i(pull_en_i),
        .rise_en_i(rise_en_i), .fall_en_i(fall_en_i), .irq_clr_i(irq_clr_i), .db_thresh_i(db_thresh_i),
        .in_o(in_o), .irq_pend_o(irq_pend_o), .irq_o(irq_o), .pad_i_o(pad_i_o),
        .pad_oen_o(pad_oen_o), .pad_ren_o(pad_ren_o), .pad_c_i(pad_c_i)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pad sample history, dir run lengths, and the edge/pending rules.
    logic [N-1:0] pad_hist[$];
    logic [N-1:0] exp_in, exp_pend, exp_oen, exp_i, exp_ren, st_in;
    logic [N-1:0] prev_in, prev_pend, prev_st, new_in, set_v;
    logic         exp_irq, all_diff, was_out;
    int           ones_run[N], zero_run[N];
    logic         from_out[N];
    int           model_th, hold;
    logic         model_ok = 1'b0;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
            model_th = int'(db_thresh_i);
`else
            model_th = 0;
`endif
            hold = T + S + 1 + model_th;
            pad_hist.delete();
            for (int k = 0; k <= S + model_th; k++) pad_hist.push_back('0);
            exp_in = '0; exp_pend = '0; exp_irq = 1'b0; exp_oen = '1; exp_i = '0; exp_ren = '1; st_in = '1;
            for (int p = 0; p < N; p++) begin
                ones_run[p] = 0; zero_run[p] = 0; from_out[p] = 1'b0;
            end
            model_ok = 1'b1;
        end else begin
            prev_in = exp_in; prev_pend = exp_pend; prev_st = st_in;
            pad_hist.push_front(pad_c_i);
            void'(pad_hist.pop_back());
            for (int p = 0; p < N; p++) begin
                // readback follows the pad once S..S+th samples all disagree with it
                all_diff = 1'b1;
                for (int k = S; k <= S + model_th; k++) if (pad_hist[k][p] == prev_in[p]) all_diff = 1'b0;
                new_in[p] = all_diff ? ~prev_in[p] : prev_in[p];
                was_out = !exp_oen[p];
                if (dir_i[p]) begin
                    if (ones_run[p] < T + 1) ones_run[p]++;
                    zero_run[p] = 0;
                end else begin
                    if (zero_run[p] == 0) from_out[p] = was_out;
                    zero_run[p]++;
                    ones_run[p] = 0;
                end
                exp_oen[p] = !(ones_run[p] >= T + 1);
                st_in[p]   = !dir_i[p] && !(from_out[p] && zero_run[p] <= hold);
            end
            set_v    = prev_st & ((~prev_in & new_in & rise_en_i) | (prev_in & ~new_in & fall_en_i));
            exp_irq  = |prev_pend;
            exp_pend = (prev_pend & ~irq_clr_i) | set_v;
            exp_in   = new_in;
            exp_i    = out_i;
            exp_ren  = ~pull_en_i;
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i && model_ok) begin
            chk("in_o", in_o, exp_in);
            chk("irq_pend_o", irq_pend_o, exp_pend);
            chk("irq_o", irq_o, exp_irq);
            chk("pad_i_o", pad_i_o, exp_i);
            chk("pad_oen_o", pad_oen_o, exp_oen);
            chk("pad_ren_o", pad_ren_o, exp_ren);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic run_random(input int cycles, input int pad_div);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk_i);
            for (int p = 0; p < N; p++) begin
                if ($urandom_range(0, 9) == 0) dir_i[p] = ~dir_i[p];
                if ($urandom_range(0, pad_div - 1) == 0) pad_c_i[p] = ~pad_c_i[p];
            end
            out_i = N'($urandom);
            if (c % 40 == 0) begin
                rise_en_i = N'($urandom);
                fall_en_i = N'($urandom);
                pull_en_i = N'($urandom);
            end
            irq_clr_i = N'($urandom & $urandom & $urandom);
        end
        @(negedge clk_i);
        irq_clr_i = '0;
    endtask

    initial begin
        #1 rst_i = 1'b1;
        tick(2);
        rst_i = 1'b0;

        // 1: asynchronous reset while pin 0 drives 1
        dir_i[0] = 1'b1; out_i[0] = 1'b1; pull_en_i = '1;
        tick(6);
        chk("pre_reset_oen0", pad_oen_o[0], 1'b0);
        #2 rst_i = 1'b1;
        #1;
        chk("rst_oen", pad_oen_o, 8'hFF);
        chk("rst_pad_i", pad_i_o, 8'h00);
        chk("rst_ren", pad_ren_o, 8'hFF);
        chk("rst_irq", irq_o, 1'b0);
        dir_i = '0; out_i = '0; pull_en_i = '0;
        tick(2);
        rst_i = 1'b0;

        // 2: turnaround timing and readback ignored during TURN_IN
        dir_i[0] = 1'b1; rise_en_i[0] = 1'b1; fall_en_i[0] = 1'b1;
        tick(1); chk("turn_e0_oen0", pad_oen_o[0], 1'b1);
        tick(1); chk("turn_e1_oen0", pad_oen_o[0], 1'b1);
        tick(1); chk("turn_e2_oen0", pad_oen_o[0], 1'b0);
        tick(2);
        dir_i[0] = 1'b0; pad_c_i[0] = 1'b1;
        tick(1); chk("turn_in_oen0", pad_oen_o[0], 1'b1);
        pad_c_i[0] = 1'b0;
        tick(8);
        chk("turn_in_pend0", irq_pend_o[0], 1'b0);
        rise_en_i[0] = 1'b0; fall_en_i[0] = 1'b0;

        // 3: one-cycle dir pulse aborts before the pad is driven
        dir_i[1] = 1'b1;
        tick(1); chk("abort_oen1", pad_oen_o[1], 1'b1);
        dir_i[1] = 1'b0;
        repeat (4) begin
            tick(1); chk("abort_oen1", pad_oen_o[1], 1'b1);
        end

        // 4: rising edge interrupt on pin 3
        rise_en_i[3] = 1'b1; pad_c_i[3] = 1'b1;
        tick(2); chk("rise_in3_e2", in_o[3], 1'b0);
        tick(1); chk("rise_in3_e3", in_o[3], 1'b1);
        chk("rise_pend3", irq_pend_o[3], 1'b1);
        chk("rise_irq_e3", irq_o, 1'b0);
        tick(1); chk("rise_irq_e4", irq_o, 1'b1);
        pad_c_i[3] = 1'b0;
        tick(4);
        chk("fall_in3", in_o[3], 1'b0);
        chk("fall_pend3", irq_pend_o[3], 1'b1);

        // 5: clear coinciding with a new edge loses; clear alone wins
        pad_c_i[3] = 1'b1;
        tick(2);
        irq_clr_i[3] = 1'b1;
        tick(1);
        irq_clr_i[3] = 1'b0;
        chk("race_in3", in_o[3], 1'b1);
        chk("race_pend3", irq_pend_o[3], 1'b1);
        irq_clr_i[3] = 1'b1;
        tick(1);
        irq_clr_i[3] = 1'b0;
        chk("clr_pend3", irq_pend_o[3], 1'b0);
        tick(1); chk("clr_irq", irq_o, 1'b0);

        run_random(1500, 5);

`ifdef GPIO_PAD_CTRL_DEBOUNCE_EN
        // 6: debounce with threshold 4
        rst_i = 1'b1;
        db_thresh_i = 8'd4;
        dir_i = '0; out_i = '0; pull_en_i = '0; rise_en_i = '0; fall_en_i = '0; pad_c_i = '0;
        tick(2);
        rst_i = 1'b0;
        pad_c_i[5] = 1'b1;
        tick(3);
        pad_c_i[5] = 1'b0;
        repeat (10) begin
            tick(1); chk("glitch_in5", in_o[5], 1'b0);
        end
        pad_c_i[5] = 1'b1;
        tick(6); chk("db_in5_e6", in_o[5], 1'b0);
        tick(1); chk("db_in5_e7", in_o[5], 1'b1);
        run_random(800, 12);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
